// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive MAC.
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_e;

    localparam logic [1:0]  DIBIT_PRE   = 2'b01;
    localparam logic [1:0]  DIBIT_SFD   = 2'b11;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    // Bit-reversed form of the IEEE polynomial 0x04C11DB7, for LSB-first shifting.
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
    localparam logic [2:0]  PRE_MIN     = 3'd4;

endpackage

// File: rtl/rmii_crc32_step.sv
// Reflected CRC-32 register advanced by one RMII dibit per enabled clock.
// dibit[0] is the earlier bit on the wire and is folded in first.
import rmii_pkg::*;

module rmii_crc32_step (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // Two serial LSB-first CRC steps, one per received bit.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 2; i++) begin
            if (crc_next[0] ^ dibit[i]) begin
                crc_next = {1'b0, crc_next[31:1]} ^ CRC_POLY_REF;
            end else begin
                crc_next = {1'b0, crc_next[31:1]};
            end
        end
    end

    // CRC register: clear wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/rmii_rx_mac.sv
// RMII receive framer: preamble/SFD detection, LSB-first byte assembly,
// FCS residue check and length/alignment verdict.
// Build option: RMII_RX_STRIP_FCS_EN holds back the last four bytes (FCS)
// through a 4-byte delay line so they are never delivered.
//
// Output stream: rx_valid is a one-cycle qualifier for rx_data and rx_sof;
// there is no backpressure, so the consumer must take every strobe.
// rx_eof is a separate one-cycle strobe that qualifies rx_fcs_ok and rx_err.
import rmii_pkg::*;

module rmii_rx_mac #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_fcs_ok,
    output logic       rx_err,
    output rx_state_e  state_dbg
);

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    rx_state_e   state;
    logic [2:0]  pre_cnt;
    logic [1:0]  phase;
    logic [5:0]  byte_q;
    logic [10:0] byte_cnt;
    logic        prev_low;
    logic        low_seen;
    logic        sof_pend;
    logic [31:0] crc_q;
`ifdef RMII_RX_STRIP_FCS_EN
    logic [3:0][7:0] dly;
    logic [2:0]      dly_cnt;
`endif

    logic       take;
    logic       end_aligned;
    logic       end_misal;
    logic       crc_clr;
    logic       fcs_ok;
    logic       len_bad;
    logic [7:0] new_byte;

    assign state_dbg = state;

    // Per-cycle decode: data take, end-of-frame kinds, CRC clear and verdict terms.
    always_comb begin
        take        = 1'b0;
        end_aligned = 1'b0;
        end_misal   = 1'b0;
        if (state == DATA) begin
            // A low after a low taken at nonzero phase is a misaligned end;
            // a lone low at phase 0 is a clean end; a lone low elsewhere is a CRS toggle.
            end_misal   = !crs_dv && prev_low;
            end_aligned = !crs_dv && !prev_low && (phase == 2'd0);
            take        = crs_dv || (!prev_low && (phase != 2'd0));
        end
        crc_clr  = (state == PREAMBLE) && crs_dv && (rxd == DIBIT_SFD) && (pre_cnt >= PRE_MIN);
        fcs_ok   = (crc_q == CRC_RESIDUE);
        len_bad  = (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
        new_byte = {rxd, byte_q};
    end

    rmii_crc32_step u_crc (
        .clk   (clk),
        .rst   (rst),
        .clr   (crc_clr),
        .en    (take),
        .dibit (rxd),
        .crc   (crc_q)
    );

    // Framing FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= 3'd0;
            phase     <= 2'd0;
            byte_q    <= 6'd0;
            byte_cnt  <= 11'd0;
            prev_low  <= 1'b0;
            low_seen  <= 1'b0;
            sof_pend  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_fcs_ok <= 1'b0;
            rx_err    <= 1'b0;
`ifdef RMII_RX_STRIP_FCS_EN
            dly       <= '0;
            dly_cnt   <= 3'd0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_fcs_ok <= 1'b0;
            rx_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (crs_dv && rxd == DIBIT_PRE) begin
                        state   <= PREAMBLE;
                        pre_cnt <= 3'd1;
                    end
                end
                PREAMBLE: begin
                    if (!crs_dv) begin
                        state    <= DROP;
                        low_seen <= 1'b0;
                    end else if (rxd == DIBIT_PRE) begin
                        if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + 3'd1;
                    end else if (crc_clr) begin
                        state    <= DATA;
                        phase    <= 2'd0;
                        byte_cnt <= 11'd0;
                        prev_low <= 1'b0;
                        sof_pend <= 1'b1;
`ifdef RMII_RX_STRIP_FCS_EN
                        dly_cnt  <= 3'd0;
`endif
                    end else begin
                        state    <= DROP;
                        low_seen <= 1'b0;
                    end
                end
                DATA: begin
                    if (end_aligned || end_misal) begin
                        rx_eof    <= 1'b1;
                        rx_fcs_ok <= fcs_ok;
                        rx_err    <= !fcs_ok || end_misal || len_bad;
                        state     <= crs_dv ? DROP : IDLE;
                        low_seen  <= 1'b0;
                    end else if (take) begin
                        prev_low <= !crs_dv;
                        phase    <= phase + 2'd1;
                        case (phase)
                            2'd0: byte_q[1:0] <= rxd;
                            2'd1: byte_q[3:2] <= rxd;
                            2'd2: byte_q[5:4] <= rxd;
                            default: begin
                                if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
`ifdef RMII_RX_STRIP_FCS_EN
                                dly <= {dly[2:0], new_byte};
                                if (dly_cnt == 3'd4) begin
                                    rx_valid <= 1'b1;
                                    rx_data  <= dly[3];
                                    rx_sof   <= sof_pend;
                                    sof_pend <= 1'b0;
                                end else begin
                                    dly_cnt <= dly_cnt + 3'd1;
                                end
`else
                                rx_valid <= 1'b1;
                                rx_data  <= new_byte;
                                rx_sof   <= sof_pend;
                                sof_pend <= 1'b0;
`endif
                            end
                        endcase
                    end
                end
                default: begin
                    // DROP: leave after two consecutive low crs_dv samples.
                    if (!crs_dv) begin
                        if (low_seen) state <= IDLE;
                        low_seen <= 1'b1;
                    end else begin
                        low_seen <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_rx_mac.sv
// Directed testbench for rmii_rx_mac (default or RMII_RX_STRIP_FCS_EN build).
import rmii_pkg::*;

module tb_rmii_rx_mac;

    typedef logic [7:0] byte_q_t[$];

    logic       clk;
    logic       rst;
    logic       crs_dv;
    logic [1:0] rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_fcs_ok;
    logic       rx_err;
    rx_state_e  state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int frames_started = 0;
    int sof_frame      = 0;
    int eof_cnt        = 0;
    logic last_ok      = 1'b0;
    logic last_err     = 1'b0;

    rmii_rx_mac #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk       (clk),
        .rst       (rst),
        .crs_dv    (crs_dv),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_fcs_ok (rx_fcs_ok),
        .rx_err    (rx_err),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference FCS: standard byte-wise reflected CRC-32, inverted, sent LSB byte first.
    function automatic byte_q_t make_frame(input int n);
        byte_q_t f;
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            f.push_back(8'(i));
            c = c ^ {24'd0, 8'(i)};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
        return f;
    endfunction

    function automatic int emitted(input int n_done);
`ifdef RMII_RX_STRIP_FCS_EN
        return (n_done > 4) ? n_done - 4 : 0;
`else
        return n_done;
`endif
    endfunction

    // Driver
    task automatic drive(input logic c, input logic [1:0] d);
        @(negedge clk);
        crs_dv = c;
        rxd    = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int p = 0; p < 4; p++) drive(1'b1, b[2*p +: 2]);
    endtask

    // Scoreboard / monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("data", 32'(rx_data), 32'(exp_q.pop_front()));
                    check("sof", 32'(rx_sof), 32'(sof_frame != frames_started));
                    sof_frame = frames_started;
                end
                if (rx_eof) check("eof_with_valid", 32'(rx_eof), 32'd0);
            end else if (rx_sof) begin
                check("sof_alone", 32'(rx_sof), 32'd0);
            end
            if (rx_eof) begin
                eof_cnt  = eof_cnt + 1;
                last_ok  = rx_fcs_ok;
                last_err = rx_err;
            end
        end
    end

    task automatic run_frame(input string tag, input byte_q_t fr, input int toggle_from,
                             input int cut_byte, input int rst_byte, input int n_done,
                             input int exp_eof, input logic chk_ok, input logic exp_ok,
                             input logic exp_err);
        int e0;
        bit aborted;
        e0 = eof_cnt;
        aborted = 0;
        frames_started++;
        for (int i = 0; i < emitted(n_done); i++) exp_q.push_back(fr[i]);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < fr.size() && !aborted; i++) begin
            for (int p = 0; p < 4 && !aborted; p++) begin
                if (i == cut_byte && p == 2) begin
                    drive(1'b0, fr[i][5:4]);
                    drive(1'b0, fr[i][7:6]);
                    aborted = 1;
                end else if (i == rst_byte && p == 2) begin
                    @(negedge clk);
                    #2 rst = 1'b1;
                    crs_dv = 1'b0;
                    #1;
                    check({tag, "_rst_data"}, 32'(rx_data), 32'd0);
                    check({tag, "_rst_state"}, 32'(state_dbg), 32'(IDLE));
                    check({tag, "_rst_flags"}, 32'({rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_err}), 32'd0);
                    @(negedge clk);
                    rst = 1'b0;
                    aborted = 1;
                end else begin
                    drive(!(toggle_from >= 0 && i >= toggle_from && p == 1), fr[i][2*p +: 2]);
                end
            end
        end
        repeat (8) drive(1'b0, 2'b00);
        check({tag, "_eofs"}, 32'(eof_cnt - e0), 32'(exp_eof));
        if (exp_eof != 0) begin
            if (chk_ok) check({tag, "_fcs_ok"}, 32'(last_ok), 32'(exp_ok));
            check({tag, "_err"}, 32'(last_err), 32'(exp_err));
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(state_dbg), 32'(IDLE));
        exp_q.delete();
    endtask

    byte_q_t good, bad, runt;
    int e_pre;

    initial begin
        rst = 1'b1;
        crs_dv = 1'b0;
        rxd = 2'b00;
        good = make_frame(60);
        bad  = make_frame(60);
        bad[10] = 8'hFF;
        runt = make_frame(36);
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data), 32'd0);
        check("reset_flags", 32'({rx_valid, rx_sof, rx_eof, rx_fcs_ok, rx_err}), 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("good",   good, -1, -1, -1, 64, 1, 1'b1, 1'b1, 1'b0);
        run_frame("badfcs", bad,  -1, -1, -1, 64, 1, 1'b1, 1'b0, 1'b1);
        run_frame("runt",   runt, -1, -1, -1, 40, 1, 1'b1, 1'b1, 1'b1);
        run_frame("misal",  good, -1, 30, -1, 30, 1, 1'b0, 1'b0, 1'b1);
        run_frame("toggle", good, 60, -1, -1, 64, 1, 1'b1, 1'b1, 1'b0);

        // Short preamble: three 01 dibits then SFD must be dropped silently.
        e_pre = eof_cnt;
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        drive(1'b1, 2'b00);
        check("shortpre_drop", 32'(state_dbg), 32'(DROP));
        for (int i = 0; i < 8; i++) drive(1'b1, 2'(i));
        repeat (4) drive(1'b0, 2'b00);
        check("shortpre_idle", 32'(state_dbg), 32'(IDLE));
        check("shortpre_eofs", 32'(eof_cnt - e_pre), 32'd0);
        run_frame("after_pre", good, -1, -1, -1, 64, 1, 1'b1, 1'b1, 1'b0);

        run_frame("rstmid",    good, -1, -1, 20, 20, 0, 1'b0, 1'b0, 1'b0);
        run_frame("after_rst", good, -1, -1, -1, 64, 1, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
